// File: rtl/rsa_pkg.sv
// Shared types and timing helpers for the constant-time modular exponentiation core.
package rsa_pkg;

  // Top-level controller states.
  typedef enum logic [2:0] {
    StIdle,
    StReduce,
    StLadA,
    StLadB,
    StDone
  } state_t;

  // Cycles spent on one modular multiply: one dispatch cycle plus multiplier latency.
  function automatic int unsigned op_cyc(input int unsigned mod_width);
    return mod_width + 2;
  endfunction

  // Cycle (relative to the accepting cycle) in which finish is high.
  function automatic int unsigned latency(input int unsigned mod_width,
                                          input int unsigned exp_width);
    return (2 * exp_width + 1) * op_cyc(mod_width) + 1;
  endfunction

  // Bits needed to hold the values 0..max_val; never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rsa_mod_mult.sv
// Interleaved shift-add modular multiplier: out = x * y mod n.
// The x operand is scanned MSB first. Every step performs the same work (shift, add,
// two trial subtractions chosen by mux), so done arrives exactly MOD_WIDTH + 1 cycles
// after start regardless of operand values.
module rsa_mod_mult
  import rsa_pkg::*;
#(
  parameter int unsigned MOD_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [MOD_WIDTH-1:0] x,
  input  logic [MOD_WIDTH-1:0] y,
  input  logic [MOD_WIDTH-1:0] n,
  output logic [MOD_WIDTH-1:0] out,
  output logic                 done
);

  // 2*acc + y < 3n < 2^(MOD_WIDTH+2) whenever acc < n and y < n.
  localparam int unsigned AccW = MOD_WIDTH + 2;
  localparam int unsigned CntW = cnt_width(MOD_WIDTH);
  localparam logic [CntW-1:0] CntLoad = CntW'(MOD_WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(1);

  logic [MOD_WIDTH-1:0] x_q;
  logic [MOD_WIDTH-1:0] y_q;
  logic [MOD_WIDTH-1:0] n_q;
  logic [AccW-1:0]      acc_q;
  logic [CntW-1:0]      cnt_q;
  logic                 run_q;
  logic                 done_q;

  logic [AccW-1:0] addend;
  logic [AccW-1:0] sum;
  logic [AccW-1:0] n_ext;
  logic [AccW-1:0] sub1;
  logic [AccW-1:0] red1;
  logic [AccW-1:0] sub2;
  logic [AccW-1:0] red2;

  // One datapath step: shift-add, then two unconditional trial subtractions.
  always_comb begin
    addend = x_q[MOD_WIDTH-1] ? {2'b00, y_q} : '0;
    sum    = (acc_q << 1) + addend;
    n_ext  = {2'b00, n_q};
    sub1   = sum - n_ext;
    red1   = (sum >= n_ext) ? sub1 : sum;
    sub2   = red1 - n_ext;
    red2   = (red1 >= n_ext) ? sub2 : red1;
  end

  // Operand capture, step sequencing and the single-cycle done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      n_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        x_q   <= x;
        y_q   <= y;
        n_q   <= n;
        acc_q <= '0;
        cnt_q <= CntLoad;
        run_q <= 1'b1;
      end else if (run_q) begin
        acc_q <= red2;
        x_q   <= x_q << 1;
        cnt_q <= cnt_q - CntLast;
        if (cnt_q == CntLast) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign out  = acc_q[MOD_WIDTH-1:0];
  assign done = done_q;

endmodule

// File: rtl/rsa_modexp_ct.sv
// Constant-time modular exponentiation: result = base^exp mod modulus.
// A Montgomery ladder issues exactly two multiplies per exponent bit (plus one initial
// reduction of base); the exponent bit only steers operand muxes and write enables,
// so latency is fixed by the parameters alone.
module rsa_modexp_ct
  import rsa_pkg::*;
#(
  parameter int unsigned MOD_WIDTH = 16,
  parameter int unsigned EXP_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [MOD_WIDTH-1:0] base,
  input  logic [EXP_WIDTH-1:0] exp,
  input  logic [MOD_WIDTH-1:0] modulus,
  output logic [MOD_WIDTH-1:0] result,
  output logic                 busy,
  output logic                 finish
);

  localparam int unsigned OpCntW = cnt_width(op_cyc(MOD_WIDTH) - 1);
  localparam int unsigned IdxW   = cnt_width(EXP_WIDTH - 1);
  localparam logic [IdxW-1:0]   IdxTop = IdxW'(EXP_WIDTH - 1);
  localparam logic [IdxW-1:0]   IdxOne = IdxW'(1);
  localparam logic [OpCntW-1:0] OpOne  = OpCntW'(1);
  localparam logic [MOD_WIDTH-1:0] One = MOD_WIDTH'(1);

  state_t state_q, state_d;

  logic [MOD_WIDTH-1:0] base_q;
  logic [EXP_WIDTH-1:0] exp_q;
  logic [MOD_WIDTH-1:0] n_q;
  logic [MOD_WIDTH-1:0] r0_q, r0_d;
  logic [MOD_WIDTH-1:0] r1_q, r1_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [OpCntW-1:0]    op_cnt_q, op_cnt_d;
  logic [MOD_WIDTH-1:0] result_q, result_d;

  logic                 cur_bit;
  logic                 n_small;
  logic                 accept;
  logic                 mul_start;
  logic [MOD_WIDTH-1:0] mul_x;
  logic [MOD_WIDTH-1:0] mul_y;
  logic [MOD_WIDTH-1:0] mul_out;
  logic                 mul_done;

  assign cur_bit = exp_q[idx_q];
  assign n_small = (n_q < MOD_WIDTH'(2));
  assign accept  = (state_q == StIdle) && start;

  // Shared multiplier, time-multiplexed across the reduction and all ladder steps.
  rsa_mod_mult #(
    .MOD_WIDTH(MOD_WIDTH)
  ) u_mul (
    .clk  (clk),
    .rst  (rst),
    .start(mul_start),
    .x    (mul_x),
    .y    (mul_y),
    .n    (n_q),
    .out  (mul_out),
    .done (mul_done)
  );

  // Operand selection: the exponent bit drives muxes only, never the op sequence.
  always_comb begin
    mul_x = r0_q;
    mul_y = r1_q;
    case (state_q)
      StReduce: begin
        // base * 1 keeps every intermediate below 2n even when base >= n.
        mul_x = base_q;
        mul_y = One;
      end
      StLadA: begin
        mul_x = r0_q;
        mul_y = r1_q;
      end
      StLadB: begin
        mul_x = cur_bit ? r1_q : r0_q;
        mul_y = cur_bit ? r1_q : r0_q;
      end
      default: ;
    endcase
  end

  // Next-state, ladder register updates, counters and result capture.
  always_comb begin
    state_d   = state_q;
    r0_d      = r0_q;
    r1_d      = r1_q;
    idx_d     = idx_q;
    op_cnt_d  = op_cnt_q;
    result_d  = result_q;
    mul_start = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StReduce;
          r0_d     = One;
          idx_d    = IdxTop;
          op_cnt_d = '0;
        end
      end
      StReduce, StLadA, StLadB: begin
        // First cycle of every op is the dispatch cycle.
        mul_start = (op_cnt_q == '0);
        op_cnt_d  = op_cnt_q + OpOne;
        if (mul_done) begin
          op_cnt_d = '0;
          case (state_q)
            StReduce: begin
              r1_d    = mul_out;
              state_d = StLadA;
            end
            StLadA: begin
              if (cur_bit) r0_d = mul_out;
              else         r1_d = mul_out;
              state_d = StLadB;
            end
            default: begin
              if (cur_bit) r1_d = mul_out;
              else         r0_d = mul_out;
              if (idx_q == '0) begin
                state_d  = StDone;
                // Modulus 0 or 1 has no meaningful residue; report 0 at the same latency.
                result_d = n_small ? '0 : r0_d;
              end else begin
                idx_d   = idx_q - IdxOne;
                state_d = StLadA;
              end
            end
          endcase
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Controller state, ladder registers and held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      r0_q     <= '0;
      r1_q     <= '0;
      idx_q    <= '0;
      op_cnt_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      r0_q     <= r0_d;
      r1_q     <= r1_d;
      idx_q    <= idx_d;
      op_cnt_q <= op_cnt_d;
      result_q <= result_d;
    end
  end

  // Operands are captured once on acceptance; the inputs are ignored afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= '0;
      exp_q  <= '0;
      n_q    <= '0;
    end else if (accept) begin
      base_q <= base;
      exp_q  <= exp;
      n_q    <= modulus;
    end
  end

  assign result = result_q;
  assign busy   = (state_q != StIdle);
  assign finish = (state_q == StDone);

endmodule

// File: tb/tb_rsa_modexp_ct.sv
// Directed bench for rsa_modexp_ct with hand-computed vectors and fixed-latency checks.
module tb_rsa_modexp_ct;

  localparam int Lat  = 595;  // (2*16 + 1) * 18 + 1
  localparam int Span = Lat + 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] base_in;
  logic [15:0] exp_in;
  logic [15:0] mod_in;
  logic [15:0] result;
  logic        busy;
  logic        finish;

  int n_assert = 0;
  int n_fail   = 0;

  int          fin_cyc;
  int          fin_cnt;
  int          busy_err;
  logic [15:0] res_fin;
  logic [15:0] res_end;

  rsa_modexp_ct #(
    .MOD_WIDTH(16),
    .EXP_WIDTH(16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .base   (base_in),
    .exp    (exp_in),
    .modulus(mod_in),
    .result (result),
    .busy   (busy),
    .finish (finish)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Issue one operation (start high in cycle 0) and watch cycles 1..Span.
  // again_cyc: cycle in which a second start with other operands is pulsed (0 = none).
  // rst_cyc: cycle in which reset is raised for two cycles (0 = none).
  task automatic run(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m,
                     input int again_cyc, input int rst_cyc);
    fin_cyc  = -1;
    fin_cnt  = 0;
    busy_err = 0;
    res_fin  = '0;
    @(negedge clk);
    base_in = b;
    exp_in  = e;
    mod_in  = m;
    start   = 1'b1;
    for (int k = 1; k <= Span; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        start   = 1'b0;
        base_in = 16'hA5A5;
        exp_in  = 16'h5A5A;
        mod_in  = 16'h0F0F;
      end
      if (finish === 1'b1) begin
        fin_cnt++;
        if (fin_cyc < 0) begin
          fin_cyc = k;
          res_fin = result;
        end
      end
      if (busy !== ((k <= Lat) && (rst_cyc == 0 || k <= rst_cyc))) busy_err++;
      if (again_cyc != 0 && k == again_cyc) begin
        start   = 1'b1;
        base_in = 16'd7;
        exp_in  = 16'd1;
        mod_in  = 16'd11;
      end
      if (again_cyc != 0 && k == again_cyc + 1) start = 1'b0;
      if (rst_cyc != 0 && k == rst_cyc) rst = 1'b1;
      if (rst_cyc != 0 && k == rst_cyc + 2) rst = 1'b0;
    end
    res_end = result;
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    base_in = '0;
    exp_in  = '0;
    mod_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", 32'(result), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_finish", 32'(finish), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 4^13 mod 497 = 445
    run(16'd4, 16'd13, 16'd497, 0, 0);
    check("known_result", 32'(res_fin), 32'd445);
    check("known_fin_cyc", 32'(fin_cyc), 32'(Lat));
    check("known_fin_cnt", 32'(fin_cnt), 32'd1);
    check("known_busy", 32'(busy_err), 32'd0);
    check("known_hold", 32'(res_end), 32'd445);

    // 600 mod 497 = 103; 103^3 mod 497 = 321
    run(16'd600, 16'd3, 16'd497, 0, 0);
    check("unreduced_result", 32'(res_fin), 32'd321);
    check("unreduced_fin_cyc", 32'(fin_cyc), 32'(Lat));

    // Constant time across exponents; 7 has order 10 mod 11, so 7^65535 = 7^5 = 10.
    run(16'd7, 16'h0001, 16'd11, 0, 0);
    check("exp1_result", 32'(res_fin), 32'd7);
    check("exp1_fin_cyc", 32'(fin_cyc), 32'(Lat));
    run(16'd7, 16'hFFFF, 16'd11, 0, 0);
    check("expffff_result", 32'(res_fin), 32'd10);
    check("expffff_fin_cyc", 32'(fin_cyc), 32'(Lat));
    run(16'd7, 16'h0000, 16'd11, 0, 0);
    check("exp0_result", 32'(res_fin), 32'd1);
    check("exp0_fin_cyc", 32'(fin_cyc), 32'(Lat));

    // Degenerate moduli report 0 at unchanged latency.
    run(16'd5, 16'd3, 16'd1, 0, 0);
    check("mod1_result", 32'(res_fin), 32'd0);
    check("mod1_fin_cyc", 32'(fin_cyc), 32'(Lat));
    run(16'd5, 16'd3, 16'd0, 0, 0);
    check("mod0_result", 32'(res_fin), 32'd0);
    check("mod0_fin_cyc", 32'(fin_cyc), 32'(Lat));

    // A start pulsed mid-run must be ignored.
    run(16'd4, 16'd13, 16'd497, 100, 0);
    check("busy_start_result", 32'(res_fin), 32'd445);
    check("busy_start_fin_cyc", 32'(fin_cyc), 32'(Lat));
    check("busy_start_fin_cnt", 32'(fin_cnt), 32'd1);
    check("busy_start_busy", 32'(busy_err), 32'd0);

    // Reset at cycle 300 aborts: no finish, outputs back to reset values.
    run(16'd4, 16'd13, 16'd497, 0, 300);
    check("abort_fin_cnt", 32'(fin_cnt), 32'd0);
    check("abort_result", 32'(res_end), 32'd0);
    check("abort_busy", 32'(busy_err), 32'd0);

    // Fresh run after the abort.
    run(16'd4, 16'd13, 16'd497, 0, 0);
    check("fresh_result", 32'(res_fin), 32'd445);
    check("fresh_fin_cyc", 32'(fin_cyc), 32'(Lat));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
